energy_event_scheduler: RTL and testbench
=========================================

ENERGY_EVENT_SCHEDULER -- requirements
Module: energy_event_scheduler

Interface
REQ-001 Parameter: NUM_CH, default 4, number of output channels sharing the energy generator.
REQ-002 Parameter: RAND_BITS, default 10, width of the occupancy random input.
REQ-003 Parameter: ENG_OUT_BITS, default 12, width of energy samples.
REQ-004 Parameter: OCC_THRESH, default 100, collision occurs when rand_in < OCC_THRESH.
REQ-005 Parameter: DEAD_TIME, default 8, cycles a channel stays blocked after its sample is accepted.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: rst  input  1  synchronous, active-high reset.
REQ-008 Port: enable  input  1  permits new collision triggers.
REQ-009 Port: rand_in  input  RAND_BITS  uniform random word, new value each cycle.
REQ-010 Port: energy_in  input  ENG_OUT_BITS  energy sample from the energy generator, new value each cycle.
REQ-011 Port: ch_ready  input  NUM_CH  per-channel consumer accept.
REQ-012 Port: ch_valid  output  NUM_CH  per-channel sample valid.
REQ-013 Port: ch_energy  output  NUM_CH*ENG_OUT_BITS  per-channel held sample; channel i at bits [i*ENG_OUT_BITS +: ENG_OUT_BITS].
REQ-014 Port: event_count  output  16  collisions triggered since reset, wraps modulo 2^16.
REQ-015 Port: drop_count  output  16  collisions with no eligible channel, saturates at 16'hFFFF.

Function
REQ-016 Trigger in cycle t SHALL be: enable=1 and rand_in < OCC_THRESH (unsigned compare); OCC_THRESH=0 never triggers.
REQ-017 Each channel SHALL run FSM IDLE -> HOLD -> DEAD -> IDLE; only IDLE channels are eligible.
REQ-018 On trigger, the first eligible channel at or after the round-robin pointer (wrapping at NUM_CH-1 -> 0) SHALL be granted.
REQ-019 Granted channel SHALL capture energy_in of cycle t and enter HOLD, with ch_valid=1 and ch_energy valid from cycle t+1 (latency 1).
REQ-020 After a grant to channel k, pointer SHALL become (k+1) mod NUM_CH; pointer unchanged when no grant.
REQ-021 In HOLD, ch_valid and ch_energy SHALL stay stable until a rising edge with ch_ready=1; that edge moves to DEAD, ch_valid=0 next cycle.
REQ-022 DEAD SHALL last exactly DEAD_TIME cycles, then IDLE; DEAD_TIME=0 SHALL go HOLD -> IDLE directly.
REQ-023 A channel accepting in cycle t SHALL NOT be eligible for a trigger in the same cycle t.
REQ-024 ch_ready while IDLE or DEAD SHALL be ignored.
REQ-025 event_count SHALL increment on every trigger, granted or dropped.
REQ-026 drop_count SHALL increment when trigger occurs and no channel is IDLE; sample discarded, no FSM changes.
REQ-027 enable=0 SHALL block triggers only; HOLD and DEAD channels continue progressing.
REQ-028 At most one channel SHALL be granted per cycle.

Reset
REQ-029 rst=1 at a rising edge SHALL force all channels IDLE, ch_valid=0, ch_energy=0, pointer=0, event_count=0, drop_count=0, dead counters=0.
REQ-030 Reset mid-HOLD or mid-DEAD SHALL abandon held samples with no acceptance; reset dominates triggers and ch_ready in the same cycle.

Structure
REQ-031 Shared package energy_sched_pkg SHALL hold the channel state enum (IDLE, HOLD, DEAD) and counter width constant (16).
REQ-032 Per-channel FSM, sample register and dead counter SHALL be sub-module energy_channel_slot, instantiated NUM_CH times; arbitration and counters in the top.

Verification
REQ-033 After reset, enable=1, rand_in=50, ch_ready=4'b1111, energy_in=12'h0A5 at cycle 0 -> ch_valid=4'b0001, ch_energy[0]=12'h0A5 at cycle 1.
REQ-034 Continuous trigger, ch_ready=0 -> grants to ch0,1,2,3 on cycles 0-3; trigger cycle 4 -> drop_count=1, event_count=5.
REQ-035 ch0 HOLD, ch_ready[0] pulsed at cycle 5, DEAD_TIME=8 -> ch0 ch_valid=0 from cycle 6, eligible again from cycle 14, not earlier.
REQ-036 rand_in=100 with OCC_THRESH=100, or enable=0 with rand_in=0 -> no grant, event_count unchanged.
REQ-037 rst asserted while ch1 HOLD and ch2 DEAD -> next cycle all ch_valid=0, counters=0, next trigger grants ch0.
REQ-038 Force 65540 drops (all channels held) -> drop_count=16'hFFFF, event_count=4 plus wraps correctly.

Source files
------------

// File: rtl/energy_sched_pkg.sv
// energy_sched_pkg: shared channel state encoding and counter width for the energy event scheduler
package energy_sched_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, DEAD} ch_state_e;
  localparam int CNT_W = 16;
endpackage

// File: rtl/energy_channel_slot.sv
// energy_channel_slot: one output channel holding a captured energy sample, then a dead-time lockout
module energy_channel_slot
  import energy_sched_pkg::*;
#(
  parameter int ENG_OUT_BITS = 12,
  parameter int DEAD_TIME    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    grant,
  input  logic                    ready,
  input  logic [ENG_OUT_BITS-1:0] sample,
  output logic                    valid,
  output logic [ENG_OUT_BITS-1:0] energy,
  output logic                    idle
);
  localparam int DW = DEAD_TIME > 1 ? $clog2(DEAD_TIME) : 1;
  // counter is loaded with DEAD_TIME-1 so DEAD spans exactly DEAD_TIME cycles
  localparam logic [DW-1:0] DLOAD = DW'(DEAD_TIME > 0 ? DEAD_TIME - 1 : 0);
  ch_state_e state, state_n;
  logic [DW-1:0] dead_cnt;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (grant ? HOLD : IDLE) :
              state == HOLD ? (ready ? (DEAD_TIME == 0 ? IDLE : DEAD) : HOLD) :
              (dead_cnt == '0 ? IDLE : DEAD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      energy   <= '0;
      dead_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && grant) energy <= sample;
      if (state == HOLD && ready) dead_cnt <= DLOAD;
      else if (state == DEAD && dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
    end
  end
  assign valid = state == HOLD;
  assign idle  = state == IDLE;
endmodule

// File: rtl/energy_event_scheduler.sv
// energy_event_scheduler: round-robin distribution of triggered energy samples over NUM_CH channels
module energy_event_scheduler
  import energy_sched_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int RAND_BITS    = 10,
  parameter int ENG_OUT_BITS = 12,
  parameter int OCC_THRESH   = 100,
  parameter int DEAD_TIME    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [RAND_BITS-1:0]           rand_in,
  input  logic [ENG_OUT_BITS-1:0]        energy_in,
  input  logic [NUM_CH-1:0]              ch_ready,
  output logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH*ENG_OUT_BITS-1:0] ch_energy,
  output logic [CNT_W-1:0]               event_count,
  output logic [CNT_W-1:0]               drop_count
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PW-1:0] ptr, gnt_idx;
  logic [NUM_CH-1:0] idle, gnt;
  logic trig, found;
  assign trig = enable && (32'(rand_in) < OCC_THRESH);
  // first idle channel at or after the pointer, wrapping around
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (!found && idle[(int'(ptr) + k) % NUM_CH]) begin
        found   = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % NUM_CH);
      end
    gnt = trig && found ? NUM_CH'(1) << gnt_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      event_count <= '0;
      drop_count  <= '0;
    end else if (trig) begin
      event_count <= event_count + 1'b1;
      if (found) ptr <= PW'((int'(gnt_idx) + 1) % NUM_CH);
      else if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    energy_channel_slot #(.ENG_OUT_BITS(ENG_OUT_BITS), .DEAD_TIME(DEAD_TIME)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .grant  (gnt[i]),
      .ready  (ch_ready[i]),
      .sample (energy_in),
      .valid  (ch_valid[i]),
      .energy (ch_energy[i*ENG_OUT_BITS +: ENG_OUT_BITS]),
      .idle   (idle[i])
    );
  end
endmodule

// File: tb/tb_energy_event_scheduler.sv
// tb_energy_event_scheduler: directed table, corner sequences and randomized run against a timeline model
module tb_energy_event_scheduler;
  localparam int N = 4, RB = 10, EB = 12, TH = 100, DT = 8;
  logic clk = 1'b0, rst, enable;
  logic [RB-1:0] rand_in;
  logic [EB-1:0] energy_in;
  logic [N-1:0] ch_ready, ch_valid;
  logic [N*EB-1:0] ch_energy;
  logic [15:0] event_count, drop_count;
  int n_cmp = 0, n_bad = 0;

  energy_event_scheduler #(.NUM_CH(N), .RAND_BITS(RB), .ENG_OUT_BITS(EB), .OCC_THRESH(TH), .DEAD_TIME(DT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rand_in(rand_in), .energy_in(energy_in),
    .ch_ready(ch_ready), .ch_valid(ch_valid), .ch_energy(ch_energy),
    .event_count(event_count), .drop_count(drop_count));

  always #5 clk = ~clk;

  // model: a channel is busy while holding, or until the cycle its lockout ends
  bit m_hold[N];
  logic [EB-1:0] m_val[N];
  int m_until[N];
  int m_ptr, m_cyc, m_ev, m_dr;

  function automatic void model_step(logic r, logic en, logic [RB-1:0] rn, logic [EB-1:0] e, logic [N-1:0] rdy);
    bit idl[N];
    int found;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_hold[i] = 0; m_val[i] = '0; m_until[i] = 0; end
      m_ptr = 0; m_ev = 0; m_dr = 0; m_cyc++;
      return;
    end
    for (int i = 0; i < N; i++) idl[i] = !m_hold[i] && m_cyc >= m_until[i];
    for (int i = 0; i < N; i++)
      if (m_hold[i] && rdy[i]) begin m_hold[i] = 0; m_until[i] = m_cyc + 1 + DT; end
    if (en && int'(rn) < TH) begin
      m_ev = (m_ev + 1) % 65536;
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && idl[(m_ptr + k) % N]) found = (m_ptr + k) % N;
      if (found < 0) m_dr = m_dr < 65535 ? m_dr + 1 : 65535;
      else begin m_hold[found] = 1; m_val[found] = e; m_ptr = (found + 1) % N; end
    end
    m_cyc++;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic en, logic [RB-1:0] rn, logic [EB-1:0] e, logic [N-1:0] rdy);
    rst = r; enable = en; rand_in = rn; energy_in = e; ch_ready = rdy;
    model_step(r, en, rn, e, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, '1, '0, '0);
    step(1, 0, '1, '0, '0);
    rst = 0;
  endtask

  function automatic logic [EB-1:0] en_of(int i);
    return ch_energy[i*EB +: EB];
  endfunction

  typedef struct { logic en; logic [RB-1:0] rn; logic exp_trig; } vec_t;
  vec_t vecs[8];

  initial begin
    logic [15:0] ev0;
    logic [N-1:0] expv;
    vecs[0] = '{1'b1, 10'd0,    1'b1};
    vecs[1] = '{1'b1, 10'd99,   1'b1};
    vecs[2] = '{1'b1, 10'd100,  1'b0};
    vecs[3] = '{1'b1, 10'd1023, 1'b0};
    vecs[4] = '{1'b0, 10'd0,    1'b0};
    vecs[5] = '{1'b0, 10'd50,   1'b0};
    vecs[6] = '{1'b1, 10'd50,   1'b1};
    vecs[7] = '{1'b1, 10'd101,  1'b0};

    do_reset();
    chk("reset_valid", ch_valid, 0);
    chk("reset_energy", ch_energy, 0);
    chk("reset_events", event_count, 0);
    chk("reset_drops", drop_count, 0);

    foreach (vecs[v]) begin
      ev0 = event_count;
      step(0, vecs[v].en, vecs[v].rn, 12'h123, '1);
      chk($sformatf("trig_vec%0d", v), 16'(event_count - ev0), 16'(vecs[v].exp_trig));
    end

    do_reset();
    step(0, 1, 50, 12'h0A5, 4'b1111);
    chk("first_grant_valid", ch_valid, 4'b0001);
    chk("first_grant_energy", en_of(0), 12'h0A5);

    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 50, 12'(12'h10 + k), '0);
      chk($sformatf("rr_valid%0d", k), ch_valid, (1 << (k + 1)) - 1);
      chk($sformatf("rr_energy%0d", k), en_of(k), 12'h10 + k);
    end
    step(0, 1, 50, 12'h777, '0);
    chk("full_drops", drop_count, 1);
    chk("full_events", event_count, 5);
    chk("full_hold_stable", en_of(0), 12'h10);

    do_reset();
    step(0, 1, 50, 12'h111, '0);
    for (int c = 1; c <= 4; c++) step(0, 0, 0, 12'h222, '0);
    chk("enable_off_hold", ch_valid, 4'b0001);
    step(0, 0, 0, 12'h222, 4'b0001);
    chk("accept_valid_drop", ch_valid, 4'b0000);
    for (int c = 6; c <= 13; c++) step(0, 1, 50, 12'(c), '0);
    chk("dead_not_eligible", ch_valid, 4'b1110);
    chk("dead_drops", drop_count, 5);
    step(0, 1, 50, 12'h3C3, '0);
    chk("dead_expired_grant", ch_valid, 4'b1111);
    chk("dead_expired_energy", en_of(0), 12'h3C3);
    chk("dead_events", event_count, 10);

    do_reset();
    step(0, 1, 50, 12'h001, '0);
    step(0, 1, 50, 12'h002, '0);
    step(0, 1, 50, 12'h003, '0);
    step(0, 0, 50, 12'h004, 4'b0100);
    step(1, 1, 50, 12'h005, 4'b1111);
    rst = 0;
    chk("midrst_valid", ch_valid, 0);
    chk("midrst_energy", ch_energy, 0);
    chk("midrst_events", event_count, 0);
    chk("midrst_drops", drop_count, 0);
    step(0, 1, 50, 12'h0BE, '0);
    chk("midrst_regrant", ch_valid, 4'b0001);

    do_reset();
    for (int k = 0; k < 4; k++) step(0, 1, 0, 12'(k), '0);
    for (int k = 0; k < 65540; k++) step(0, 1, 0, 12'h5A5, '0);
    chk("sat_drops", drop_count, 16'hFFFF);
    chk("wrap_events", event_count, 16'd8);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r, en;
      logic [RB-1:0] rn;
      r  = $urandom_range(0, 199) == 0;
      en = $urandom_range(0, 4) != 0;
      rn = $urandom_range(0, 1) ? RB'($urandom_range(0, 150)) : RB'($urandom_range(0, 1023));
      step(r, en, rn, EB'($urandom), N'($urandom) & N'($urandom));
      expv = '0;
      for (int i = 0; i < N; i++) expv[i] = m_hold[i];
      chk("rand_valid", ch_valid, expv);
      for (int i = 0; i < N; i++)
        if (m_hold[i]) chk($sformatf("rand_energy%0d", i), en_of(i), m_val[i]);
      chk("rand_events", event_count, 16'(m_ev));
      chk("rand_drops", drop_count, 16'(m_dr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
